// File: rtl/mips_pipe_pkg.sv
// Shared types and widths for the MIPS pipeline MEM stage.
package mips_pipe_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic [DATA_W-1:0]     branch_target;
      logic                  zero;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     read_data2;
      logic [REG_ADDR_W-1:0] write_reg;
   } exmem_t;

   // An entry does something architecturally visible.
   function automatic logic is_live(input exmem_t e);
      return e.reg_write | e.mem_read | e.mem_write | e.branch;
   endfunction

   // An entry needs the data-memory bus.
   function automatic logic is_access(input exmem_t e);
      return e.mem_read | e.mem_write;
   endfunction

endpackage

// File: rtl/mem_skid_slot.sv
// One-entry EX/MEM skid register; load wins over clear.
module mem_skid_slot
   import mips_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   i_load,
   input  logic   i_clear,
   input  exmem_t i_data,
   output exmem_t o_data,
   output logic   o_valid
);

   exmem_t r_data;
   logic   r_valid;

   // Capture an entry on load, drop it on clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, req/ack data-memory access, MEM/WB register.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
   import mips_pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = mips_pipe_pkg::DATA_W,
   parameter int unsigned ADDR_W     = mips_pipe_pkg::ADDR_W,
   parameter int unsigned REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  em_mem_to_reg,
   input  logic                  em_reg_write,
   input  logic                  em_mem_read,
   input  logic                  em_mem_write,
   input  logic                  em_branch,
   input  logic [DATA_W-1:0]     em_branch_target,
   input  logic                  em_zero,
   input  logic [DATA_W-1:0]     em_alu_result,
   input  logic [DATA_W-1:0]     em_read_data2,
   input  logic [REG_ADDR_W-1:0] em_write_reg,
   output logic                  pc_src,
   output logic [DATA_W-1:0]     pc_branch_target,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ack,
   output logic                  wb_mem_to_reg,
   output logic                  wb_reg_write,
   output logic [DATA_W-1:0]     wb_read_data,
   output logic [DATA_W-1:0]     wb_alu_result,
   output logic [REG_ADDR_W-1:0] wb_write_reg,
   output logic                  align_err
);

   mem_state_t r_state, w_state_n;
   exmem_t     w_em, w_src, w_skid_data;
   logic       w_skid_valid, w_skid_load, w_skid_clear;
   logic       w_misaligned;

   // Bus request and held control of the outstanding access.
   logic                  r_mem_req, r_mem_we, r_hold_m2r, r_hold_rw;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_mem_wdata;
   logic [REG_ADDR_W-1:0] r_hold_wreg;
   logic                  w_mem_req_n, w_mem_we_n, w_hold_m2r_n, w_hold_rw_n;
   logic [ADDR_W-1:0]     w_mem_addr_n;
   logic [DATA_W-1:0]     w_mem_wdata_n;
   logic [REG_ADDR_W-1:0] w_hold_wreg_n;

   // MEM/WB register.
   logic                  r_wb_m2r, r_wb_rw;
   logic [DATA_W-1:0]     r_wb_rdata, r_wb_alu;
   logic [REG_ADDR_W-1:0] r_wb_wreg;
   logic                  w_wb_m2r_n, w_wb_rw_n;
   logic [DATA_W-1:0]     w_wb_rdata_n, w_wb_alu_n;
   logic [REG_ADDR_W-1:0] w_wb_wreg_n;

`ifdef MEM_ALIGN_CHECK_EN
   logic r_align_err, w_align_err_n;
   assign w_misaligned = (w_src.alu_result[1:0] != 2'b00);
   assign align_err    = r_align_err;
`else
   assign w_misaligned = 1'b0;
   assign align_err    = 1'b0;
`endif

   assign w_em = '{mem_to_reg:    em_mem_to_reg,
                   reg_write:     em_reg_write,
                   mem_read:      em_mem_read,
                   mem_write:     em_mem_write,
                   branch:        em_branch,
                   branch_target: em_branch_target,
                   zero:          em_zero,
                   alu_result:    em_alu_result,
                   read_data2:    em_read_data2,
                   write_reg:     em_write_reg};

   mem_skid_slot u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (w_em),
      .o_data  (w_skid_data),
      .o_valid (w_skid_valid)
   );

   // The skid entry is older than whatever sits on em_*.
   assign w_src            = w_skid_valid ? w_skid_data : w_em;
   assign stall            = (r_state == BUSY) | w_skid_valid;
   assign pc_src           = (r_state == IDLE) & w_src.branch & w_src.zero;
   assign pc_branch_target = w_src.branch_target;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_n;
   end

   // Next state: launch an aligned access from IDLE, return on ack.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:    if (is_access(w_src) && !w_misaligned) w_state_n = BUSY;
         BUSY:    if (mem_ack) w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   // Next values of the bus, holding and MEM/WB registers; bubble by default.
   always_comb begin
      w_mem_req_n   = r_mem_req;
      w_mem_we_n    = r_mem_we;
      w_mem_addr_n  = r_mem_addr;
      w_mem_wdata_n = r_mem_wdata;
      w_hold_m2r_n  = r_hold_m2r;
      w_hold_rw_n   = r_hold_rw;
      w_hold_wreg_n = r_hold_wreg;
      w_wb_m2r_n    = 1'b0;
      w_wb_rw_n     = 1'b0;
      w_wb_rdata_n  = '0;
      w_wb_alu_n    = '0;
      w_wb_wreg_n   = '0;
      w_skid_load   = 1'b0;
      w_skid_clear  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      w_align_err_n = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            w_skid_clear = w_skid_valid;
            if (is_access(w_src)) begin
               if (w_misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                  w_align_err_n = 1'b1;
`endif
               end else begin
                  w_mem_req_n   = 1'b1;
                  w_mem_we_n    = w_src.mem_write;
                  w_mem_addr_n  = w_src.alu_result[ADDR_W-1:0];
                  w_mem_wdata_n = w_src.read_data2;
                  w_hold_m2r_n  = w_src.mem_to_reg;
                  w_hold_rw_n   = w_src.reg_write;
                  w_hold_wreg_n = w_src.write_reg;
               end
            end else begin
               w_wb_m2r_n  = w_src.mem_to_reg;
               w_wb_rw_n   = w_src.reg_write;
               w_wb_alu_n  = w_src.alu_result;
               w_wb_wreg_n = w_src.write_reg;
            end
         end
         BUSY: begin
            w_skid_load = !w_skid_valid && is_live(w_em);
            if (mem_ack) begin
               w_mem_req_n  = 1'b0;
               w_wb_m2r_n   = r_hold_m2r;
               w_wb_rw_n    = r_hold_rw;
               w_wb_rdata_n = r_mem_we ? '0 : mem_rdata;
               w_wb_alu_n   = DATA_W'(r_mem_addr);
               w_wb_wreg_n  = r_hold_wreg;
            end
         end
         default: ;
      endcase
   end

   // Registered bus, holding and MEM/WB outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_hold_m2r  <= 1'b0;
         r_hold_rw   <= 1'b0;
         r_hold_wreg <= '0;
         r_wb_m2r    <= 1'b0;
         r_wb_rw     <= 1'b0;
         r_wb_rdata  <= '0;
         r_wb_alu    <= '0;
         r_wb_wreg   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         r_align_err <= 1'b0;
`endif
      end else begin
         r_mem_req   <= w_mem_req_n;
         r_mem_we    <= w_mem_we_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_wdata <= w_mem_wdata_n;
         r_hold_m2r  <= w_hold_m2r_n;
         r_hold_rw   <= w_hold_rw_n;
         r_hold_wreg <= w_hold_wreg_n;
         r_wb_m2r    <= w_wb_m2r_n;
         r_wb_rw     <= w_wb_rw_n;
         r_wb_rdata  <= w_wb_rdata_n;
         r_wb_alu    <= w_wb_alu_n;
         r_wb_wreg   <= w_wb_wreg_n;
`ifdef MEM_ALIGN_CHECK_EN
         r_align_err <= w_align_err_n;
`endif
      end
   end

   assign mem_req       = r_mem_req;
   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign wb_mem_to_reg = r_wb_m2r;
   assign wb_reg_write  = r_wb_rw;
   assign wb_read_data  = r_wb_rdata;
   assign wb_alu_result = r_wb_alu;
   assign wb_write_reg  = r_wb_wreg;

endmodule
